// File: rtl/alu_exec_unit.sv
// Handshaked ALU: single-cycle arithmetic/logic ops, and bit-serial SLL/SRL
// that shift one position per cycle under a 5-bit down-counter.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             b31,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       cnt_q;
  logic             dir_right_q;

  logic [4:0]       shamt;
  logic             multi_cycle;
  logic [WIDTH-1:0] alu_res;

  assign shamt       = op_b[4:0];
  assign multi_cycle = (alu_control[2:1] == 2'b11) && (shamt != 5'd0);

  always_comb begin
    alu_res = '0;
    unique case (alu_control)
      3'b000: alu_res = op_a + op_b;
      3'b001: alu_res = op_a - op_b;
      3'b010: alu_res = op_a & op_b;
      3'b011: alu_res = op_a | op_b;
      3'b100: alu_res = op_a ^ op_b;
      3'b101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      // Zero-amount shifts complete immediately with the operand unchanged.
      3'b110: alu_res = op_a;
      3'b111: alu_res = op_a;
      default: alu_res = '0;
    endcase
  end

  // result_q doubles as the shift working register while in StShift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      result_q    <= '0;
      cnt_q       <= 5'd0;
      dir_right_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            dir_right_q <= alu_control[0];
            if (multi_cycle) begin
              result_q <= op_a;
              cnt_q    <= shamt;
              state_q  <= StShift;
            end else begin
              result_q <= alu_res;
              state_q  <= StDone;
            end
          end
        end
        StShift: begin
          result_q <= dir_right_q ? (result_q >> 1) : (result_q << 1);
          cnt_q    <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign b31       = result_q[WIDTH-1];

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be >= 8.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  the operation request is valid.
REQ-005 in_ready  output  1  the unit can accept a request.
REQ-006 alu_control  input  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
REQ-007 op_a  input  WIDTH  first operand.
REQ-008 op_b  input  WIDTH  second operand; op_b[4:0] is the shift amount for SLL/SRL.
REQ-009 out_valid  output  1  result and flags are valid.
REQ-010 out_ready  input  1  the consumer accepts the result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  result equals 0; feeds the branch condition logic.
REQ-013 b31  output  1  result[WIDTH-1]; feeds the branch condition logic (BLT/BGE).
REQ-014 busy  output  1  the unit is not in IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; a request SHALL be accepted on the rising edge with in_valid=1 and in_ready=1.
REQ-017 On acceptance the unit SHALL register alu_control, op_a and op_b; later input changes SHALL NOT affect the operation in flight.
REQ-018 For codes 000-101, the result SHALL be registered and the FSM SHALL go to DONE on the acceptance edge, so out_valid=1 in the next cycle (latency 1).
REQ-019 ADD and SUB SHALL be modulo 2^WIDTH, with carry and borrow discarded.
REQ-020 SLT SHALL produce 1 if op_a < op_b as two's-complement signed values, else 0, zero-extended to WIDTH.
REQ-021 For SLL/SRL with shamt = op_b[4:0] = 0, the unit SHALL go to DONE with result = op_a (latency 1).
REQ-022 For SLL/SRL with shamt > 0, the unit SHALL load op_a into the working register, load shamt into a 5-bit down-counter, and enter SHIFT.
REQ-023 In each SHIFT cycle the working register SHALL shift by one bit (SLL: left, zero-fill; SRL: logical right, zero-fill) and the counter SHALL decrement.
REQ-024 The unit SHALL go to DONE on the edge where the counter goes from 1 to 0, giving out_valid latency = shamt + 1 cycles after acceptance.
REQ-025 In DONE, out_valid SHALL be 1 and result, zero and b31 SHALL be held stable until the edge where out_ready=1.
REQ-026 On the edge in DONE where out_ready=1, the unit SHALL return to IDLE; back-to-back issue is therefore at most one operation every 2 cycles.
REQ-027 zero and b31 SHALL be derived from the registered result only and SHALL be valid whenever out_valid=1.
REQ-028 An in_valid pulse while in_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-029 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.

Reset
REQ-030 When rst_n=0 at a rising edge, the unit SHALL go to IDLE, from any state including mid-SHIFT and DONE, and SHALL discard any operation in flight.
REQ-031 During and after reset, outputs SHALL be: in_ready=1, out_valid=0, busy=0, result=0, zero=1, b31=0, shift counter=0.
REQ-032 If rst_n=0 and in_valid=1 on the same edge, reset SHALL take priority and no request SHALL be accepted.

Verification
REQ-033 ADD: a=0x7FFFFFFF, b=1, out_ready=1 -> out_valid 1 cycle after acceptance, result=0x80000000, zero=0, b31=1.
REQ-034 SUB equal operands: a=b=0x1234 -> result=0, zero=1, b31=0; SUB a=3, b=5 -> result=0xFFFFFFFE, b31=1.
REQ-035 SLT signed: a=0xFFFFFFFF, b=1 -> result=1; a=1, b=0xFFFFFFFF -> result=0.
REQ-036 SLL a=0x1, b=31 -> in_ready=0 for 32 cycles, out_valid on cycle 32, result=0x80000000; SRL a=0x80000000, b=0 -> result=0x80000000 after 1 cycle.
REQ-037 Backpressure: out_ready=0 for 5 cycles in DONE -> result and flags held, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE on the next edge.
REQ-038 Reset mid-op: SRL with shamt=10, rst_n=0 after 4 SHIFT cycles -> next cycle state IDLE, out_valid=0, result=0, zero=1, in_ready=1.
